nibble_cpu_core: RTL and testbench
==================================

// Module: nibble_cpu_core
// PURPOSE
//  Parametrised successor of the board's register-display CPU. Executes 8-bit
//  instructions from a 16-entry program RAM on an 8-entry register file of
//  DATA_W bits, one instruction per step tick. Adds RUN/HALT mode, single-step,
//  a HLT instruction and run-time program load.
//  A row-scan output drives the 8x8 LED matrix with the live register file.
// PARAMETERS
//  DATA_W    4        register width; must be >= 4; immediates zero-extend
//  STEP_DIV  8388608  clk cycles per step tick in RUN; must be >= 2
//  SCAN_DIV  8192     clk cycles per matrix row; must be >= 2
// PORTS
//  clk        in   1       system clock; the only clock
//  rst        in   1       synchronous, active-high reset
//  btn        in   DATA_W  input port, sampled into r5 on every executed step
//  run        in   1       level: 1 = free-run, 0 = halt after current step
//  step       in   1       one-clk pulse; executes one instruction in HALT
//  prog_we    in   1       program write strobe; honoured only in HALT
//  prog_addr  in   4       program write address
//  prog_data  in   8       program write data
//  col        out  DATA_W  register bits of the scanned row, active-high
//  row        out  8       one-cold row select; row[k]=0 shows r[k]
//  c_flag     out  1       carry flag
//  halted     out  1       1 while in HALT
// BEHAVIOUR
//  Reset: all regs, C, prescalers and scan index = 0; state=HALT; halted=1;
//   col=r0=0; row=8'hFE. Program RAM is NOT cleared.
//  r7 is the PC: low 4 bits address the program RAM. r5 <= btn before decode.
//  FSM HALT->RUN when run=1 (prescaler restarts at 0). RUN->HALT when run=0
//   at a tick boundary, or on a HLT instruction.
//  Step tick: in RUN, every STEP_DIV clks; in HALT, step=1 (run=0) fires one tick
//   on the next clk. One instruction executes per tick; latency is 1 clk.
//  Decode of the instruction at ram[r7[3:0]], with s=ins[2:0] and d=ins[5:3]:
//   00dddsss mov rd,rs    | 01000sss add r0+=rs, C|=carry-out
//   01001sss or r0|=rs    | 01010sss and r0&=rs | 01011sss xor r0^=rs
//   01100sss inc rs, C|=wrap | 01101sss not rs (bitwise)
//   01110sss ror rs by 1  | 01111sss rol rs by 1 (rotate within DATA_W)
//   1000iiii jnc: C=0 -> PC=i, else PC+1; C cleared either way
//   1001iiii jmp PC=i     | 1010iiii mvi r0=i   | 1011xxxx hlt (PC+1, go HALT)
//   11xxxxxx nop
//  PC increments mod 16 (upper r7 bits cleared) except on jmp/jnc-taken.
//   An ALU op whose destination is r7 writes PC and suppresses the increment.
//   A destination of r5 is overwritten by btn on the next step.
//  C is sticky: only jnc clears it. All arithmetic wraps modulo 2^DATA_W.
//  prog_we while RUN is ignored. prog_we coinciding with a HALT step writes
//   first; the step fetches the new word.
//  Scan: every SCAN_DIV clks the row index advances 0..7 and wraps. The scan
//   runs in both states; col = r[index], registered.
//  rst overrides all activity, including a step, a write or a scan in progress.
// TESTING
//  rst, load mvi r0,2; mov r1,r0; hlt -> 3 step pulses: r1=2, halted, r7=3
//  DATA_W=4: r0=15, add r0 (01000000) -> r0=14, C=1; then jnc 0 -> PC+1, C=0
//  inc r6 from 15 -> r6=0, C=1; ror of 4'b0001 -> 4'b1000; rol -> 4'b0001
//  run=1, STEP_DIV=4, prog 9:jmp 9 -> r7 stays 9; run=0 -> halted=1 at a tick
//  prog_we during RUN -> RAM unchanged; rst mid-RUN -> r0..r7=0, halted=1
//  SCAN_DIV=2: row walks FE,FD,...,7F,FE with col=r[k]; DATA_W=8 add carry ok

Source files
------------

// File: rtl/nibble_cpu_core.sv
// nibble_cpu_core: 8-bit-instruction CPU with an 8 x DATA_W register file (r7 = PC),
// 16-word program RAM, RUN/HALT stepping and a row-scanned LED matrix output.
module nibble_cpu_core #(
    parameter int DATA_W   = 4,
    parameter int STEP_DIV = 8388608,
    parameter int SCAN_DIV = 8192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] btn,
    input  logic              run,
    input  logic              step,
    input  logic              prog_we,
    input  logic [3:0]        prog_addr,
    input  logic [7:0]        prog_data,
    output logic [DATA_W-1:0] col,
    output logic [7:0]        row,
    output logic              c_flag,
    output logic              halted
);

    localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    typedef enum logic {ST_HALT, ST_RUN} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] regs     [8];
    logic [DATA_W-1:0] regs_nxt [8];
    logic [7:0]        prog_ram [16];
    logic [STEP_W-1:0] step_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        scan_idx;

    logic              tick;
    logic              ram_we;
    logic              c_nxt;
    logic              hlt_exec;
    logic [7:0]        ins;
    logic [3:0]        pc;
    logic [3:0]        pc_inc;
    logic [2:0]        sel_s, sel_d, dest;
    logic [DATA_W-1:0] src, acc, res, imm;
    logic [DATA_W:0]   sum;
    logic              wr, jump;

    assign pc     = regs[7][3:0];
    assign pc_inc = pc + 4'd1;
    assign ram_we = prog_we && (state == ST_HALT);
    assign halted = (state == ST_HALT);

    // A write landing on the PC's address in the same clk as a step is
    // forwarded, so the step executes the freshly written word.
    assign ins = (ram_we && (prog_addr == pc)) ? prog_data : prog_ram[pc];

    assign tick = (state == ST_RUN) ? (step_cnt == STEP_LAST) : (step && !run);

    // NOTE: program RAM has no reset branch so it maps onto plain memory and
    // survives rst; only the addressed word is ever written.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            prog_ram[prog_addr] <= prog_data;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value held and no latch is inferred.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_nxt[i] = regs[i];
        end
        regs_nxt[5] = btn;
        c_nxt    = c_flag;
        hlt_exec = 1'b0;
        wr       = 1'b0;
        jump     = 1'b0;
        sel_s    = ins[2:0];
        sel_d    = ins[5:3];
        dest     = 3'd0;
        src      = regs_nxt[sel_s];
        acc      = regs_nxt[0];
        imm      = DATA_W'(ins[3:0]);
        sum      = {1'b0, acc} + {1'b0, src};
        res      = '0;

        casez (ins)
            8'b00??????: begin dest = sel_d; res = src;       wr = 1'b1; end
            8'b01000???: begin
                res   = sum[DATA_W-1:0];
                wr    = 1'b1;
                c_nxt = c_flag | sum[DATA_W];
            end
            8'b01001???: begin res = acc | src; wr = 1'b1; end
            8'b01010???: begin res = acc & src; wr = 1'b1; end
            8'b01011???: begin res = acc ^ src; wr = 1'b1; end
            8'b01100???: begin
                dest  = sel_s;
                res   = src + 1'b1;
                wr    = 1'b1;
                c_nxt = c_flag | (&src);
            end
            8'b01101???: begin dest = sel_s; res = ~src; wr = 1'b1; end
            8'b01110???: begin dest = sel_s; res = {src[0], src[DATA_W-1:1]}; wr = 1'b1; end
            8'b01111???: begin dest = sel_s; res = {src[DATA_W-2:0], src[DATA_W-1]}; wr = 1'b1; end
            8'b1000????: begin jump = !c_flag; c_nxt = 1'b0; end
            8'b1001????: jump = 1'b1;
            8'b1010????: begin res = imm; wr = 1'b1; end
            8'b1011????: hlt_exec = 1'b1;
            default:     ;
        endcase

        if (wr) begin
            regs_nxt[dest] = res;
        end
        // A write to r7 is the new PC; otherwise PC jumps or steps mod 16.
        if (jump) begin
            regs_nxt[7] = DATA_W'(ins[3:0]);
        end else if (!(wr && dest == 3'd7)) begin
            regs_nxt[7] = DATA_W'(pc_inc);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HALT: if (run) state_nxt = ST_RUN;
            ST_RUN:  if (tick && (!run || hlt_exec)) state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // Held at zero outside RUN so entering RUN restarts the step period.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RUN) begin
            step_cnt <= '0;
        end else if (step_cnt == STEP_LAST) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
            c_flag <= 1'b0;
        end else if (tick) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= regs_nxt[i];
            end
            c_flag <= c_nxt;
        end
    end

    // row and col are registered from the same index so they change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= 3'd0;
            col      <= '0;
            row      <= 8'hFE;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                scan_idx <= scan_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            col <= regs[scan_idx];
            row <= ~(8'd1 << scan_idx);
        end
    end

endmodule

// File: tb/tb_nibble_cpu_core.sv
// Scoreboard bench for nibble_cpu_core: expected register-file frames are queued by the
// stimulus and compared by a monitor that reads them back through the LED row scan.
module tb_nibble_cpu_core;

    logic       clk = 1'b0;
    logic       rst, run, step, step8, prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] btn;
    logic [7:0] btn8;
    logic [3:0] col4;
    logic [7:0] row4, col8, row8;
    logic       c4, halted4, c8, halted8;

    always #5 clk = ~clk;

    nibble_cpu_core #(.DATA_W(4), .STEP_DIV(4), .SCAN_DIV(2)) dut (
        .clk(clk), .rst(rst), .btn(btn), .run(run), .step(step),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .col(col4), .row(row4), .c_flag(c4), .halted(halted4)
    );

    nibble_cpu_core #(.DATA_W(8), .STEP_DIV(4), .SCAN_DIV(2)) dut8 (
        .clk(clk), .rst(rst), .btn(btn8), .run(1'b0), .step(step8),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .col(col8), .row(row8), .c_flag(c8), .halted(halted8)
    );

    typedef struct {
        int          id;
        bit          sel;
        logic [63:0] regs;
        logic        c;
        logic        halted;
    } exp_t;

    exp_t       sb[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         id_cnt = 0;
    logic [7:0] e [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rd_row(input bit sel);
        return sel ? row8 : row4;
    endfunction

    function automatic logic [7:0] rd_col(input bit sel);
        return sel ? col8 : {4'h0, col4};
    endfunction

    // Collect one full scan frame r0..r7 and verify the row walk FE..7F,FE.
    task automatic capture(input bit sel, output logic [63:0] got, output bit walk_ok);
        int         n;
        logic [7:0] prev, exp_row;
        walk_ok = 1'b1;
        got     = '0;
        n       = 0;
        while (rd_row(sel) != 8'hFE && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) walk_ok = 1'b0;
        got[7:0] = rd_col(sel);
        prev     = rd_row(sel);
        for (int k = 1; k <= 8 && walk_ok; k++) begin
            n = 0;
            while (rd_row(sel) == prev && n < 64) begin
                @(negedge clk);
                n++;
            end
            if (n >= 64) walk_ok = 1'b0;
            exp_row = (k == 8) ? 8'hFE : ~(8'd1 << k);
            if (rd_row(sel) != exp_row) walk_ok = 1'b0;
            if (k < 8) got[k*8 +: 8] = rd_col(sel);
            prev = rd_row(sel);
        end
    endtask

    initial begin : monitor
        exp_t        it;
        logic [63:0] got;
        bit          walk_ok;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                it = sb[0];
                capture(it.sel, got, walk_ok);
                check($sformatf("frame%0d scan_walk", it.id), 64'(walk_ok), 64'd1);
                check($sformatf("frame%0d regs", it.id), got, it.regs);
                check($sformatf("frame%0d c_flag", it.id), it.sel ? c8 : c4, it.c);
                check($sformatf("frame%0d halted", it.id), it.sel ? halted8 : halted4, it.halted);
                void'(sb.pop_front());
            end
        end
    end

    task automatic push_exp(input bit sel, input logic c, input logic h);
        exp_t it;
        int   n;
        it.id     = id_cnt++;
        it.sel    = sel;
        it.c      = c;
        it.halted = h;
        for (int k = 0; k < 8; k++) it.regs[k*8 +: 8] = e[k];
        sb.push_back(it);
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("frame%0d drained", it.id), 64'(sb.size()), 64'd0);
    endtask

    task automatic load(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic do_step(input bit sel);
        @(negedge clk);
        if (sel) step8 = 1'b1; else step = 1'b1;
        @(negedge clk);
        step = 1'b0; step8 = 1'b0;
    endtask

    task automatic step_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = a; prog_data = d; step = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; step = 1'b0;
    endtask

    localparam logic [7:0] PROG [16] = '{
        8'hA2, 8'h08, 8'hB0, 8'hAF, 8'h40, 8'h80, 8'hAF, 8'h30,
        8'h66, 8'hA1, 8'h70, 8'h78, 8'h8E, 8'h8F, 8'hC0, 8'h39
    };

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        rst = 1'b1; run = 1'b0; step = 1'b0; step8 = 1'b0; prog_we = 1'b0;
        prog_addr = '0; prog_data = '0; btn = 4'hA; btn8 = 8'h5A;
        for (int k = 0; k < 8; k++) e[k] = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_row", row4, 8'hFE);
        check("rst_col", col4, 4'h0);
        check("rst_halted", halted4, 1'b1);
        check("rst_c", c4, 1'b0);
        rst = 1'b0;

        for (int a = 0; a < 16; a++) load(4'(a), PROG[a]);
        push_exp(1'b0, 1'b0, 1'b1);

        // mvi r0,2 ; mov r1,r0 ; hlt
        repeat (3) do_step(1'b0);
        e[0] = 8'h2; e[1] = 8'h2; e[5] = 8'hA; e[7] = 8'h3;
        push_exp(1'b0, 1'b0, 1'b1);

        // mvi r0,15 ; add r0,r0 -> 14 with carry
        repeat (2) do_step(1'b0);
        e[0] = 8'hE; e[7] = 8'h5;
        push_exp(1'b0, 1'b1, 1'b1);

        // jnc 0 with C=1 -> fall through and clear C
        do_step(1'b0);
        e[7] = 8'h6;
        push_exp(1'b0, 1'b0, 1'b1);

        // mvi r0,15 ; mov r6,r0 ; inc r6 -> wraps to 0, C=1
        repeat (3) do_step(1'b0);
        e[0] = 8'hF; e[6] = 8'h0; e[7] = 8'h9;
        push_exp(1'b0, 1'b1, 1'b1);

        // mvi r0,1 ; ror r0 -> 1000
        repeat (2) do_step(1'b0);
        e[0] = 8'h8; e[7] = 8'hB;
        push_exp(1'b0, 1'b1, 1'b1);

        do_step(1'b0);
        e[0] = 8'h1; e[7] = 8'hC;
        push_exp(1'b0, 1'b1, 1'b1);

        // jnc 14 not taken (C=1), jnc 15 taken (C=0), mov r7,r1
        do_step(1'b0);
        e[7] = 8'hD;
        push_exp(1'b0, 1'b0, 1'b1);
        do_step(1'b0);
        e[7] = 8'hF;
        push_exp(1'b0, 1'b0, 1'b1);
        do_step(1'b0);
        e[7] = 8'h2;
        push_exp(1'b0, 1'b0, 1'b1);

        load(4'd3, 8'h55); load(4'd4, 8'h5D); load(4'd5, 8'h6B); load(4'd6, 8'h15);
        load(4'd7, 8'hC0); load(4'd8, 8'h99); load(4'd9, 8'h99);

        // write or r0,r1 at the PC in the same clk as the step
        step_write(4'd2, 8'h49);
        e[0] = 8'h3; e[7] = 8'h3;
        push_exp(1'b0, 1'b0, 1'b1);

        do_step(1'b0);
        e[0] = 8'h2; e[7] = 8'h4;
        push_exp(1'b0, 1'b0, 1'b1);

        repeat (2) do_step(1'b0);
        e[0] = 8'h8; e[3] = 8'hF; e[7] = 8'h6;
        push_exp(1'b0, 1'b0, 1'b1);

        // mov r2,r5 sees the freshly sampled btn; then nop
        btn = 4'h3;
        repeat (2) do_step(1'b0);
        e[2] = 8'h3; e[5] = 8'h3; e[7] = 8'h8;
        push_exp(1'b0, 1'b0, 1'b1);

        // free-run on jmp 9; a program write while running is dropped
        @(negedge clk);
        run = 1'b1;
        repeat (8) @(negedge clk);
        load(4'd9, 8'hC0);
        e[7] = 8'h9;
        push_exp(1'b0, 1'b0, 1'b0);

        run = 1'b0;
        n = 0;
        while (!halted4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("halt_after_run0", halted4, 1'b1);
        push_exp(1'b0, 1'b0, 1'b1);

        do_step(1'b0);
        push_exp(1'b0, 1'b0, 1'b1);

        // reset in the middle of RUN; program RAM must survive it
        @(negedge clk);
        run = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1; run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) e[k] = 8'h00;
        push_exp(1'b0, 1'b0, 1'b1);

        do_step(1'b0);
        e[0] = 8'h2; e[5] = 8'h3; e[7] = 8'h1;
        push_exp(1'b0, 1'b0, 1'b1);

        // DATA_W=8: mvi r0,15 ; not r0 ; mov r1,r0 ; add r0,r1 -> E0, C=1
        load(4'd0, 8'hAF); load(4'd1, 8'h68); load(4'd2, 8'h08); load(4'd3, 8'h41);
        repeat (4) do_step(1'b1);
        for (int k = 0; k < 8; k++) e[k] = 8'h00;
        e[0] = 8'hE0; e[1] = 8'hF0; e[5] = 8'h5A; e[7] = 8'h04;
        push_exp(1'b1, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
